letc_core_mem_arbiter: RTL and testbench



---
 rtl/letc_core_mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_letc_core_mem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/letc_core_mem_arbiter.sv
// letc_core_mem_arbiter
//   Shares the core's single memory port between instruction fetch and the
//   load/store stage. Only one transaction is outstanding at a time. Arbitration
//   between the two requesters is round-robin.
//   For a data access the block also does the following:
//     - checks alignment and size,
//     - replicates store data onto the proper byte lanes with matching strobes,
//     - extracts the addressed byte or halfword from the returned word and
//       sign- or zero-extends it.
//
// Ports
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_if_req/i_if_addr     fetch request, word address [31:2]
//   o_if_ready             fetch request accepted this cycle
//   o_if_rvalid/o_if_rdata fetch response pulse and instruction word
//   i_d_req/i_d_addr       data request, byte address
//   i_d_wen/i_d_size       store enable, access size (00 B, 01 H, 10 W, 11 illegal)
//   i_d_unsigned           zero-extend loads
//   i_d_wdata              store data, LSB-aligned
//   o_d_ready              data request accepted this cycle
//   o_d_rvalid/o_d_rdata   data response pulse and extended load data
//   o_d_fault              qualifies o_d_rvalid: misaligned or illegal size
//   o_mem_*/i_mem_*        memory bus: request handshake, response, data
module letc_core_mem_arbiter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [29:0] i_if_addr,
  output logic        o_if_ready,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic [31:0] i_d_addr,
  input  logic        i_d_wen,
  input  logic [1:0]  i_d_size,
  input  logic        i_d_unsigned,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_ready,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic        o_d_fault,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [29:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, FAULT} state_t;

  state_t      state, state_next;
  logic        prio_data;
  logic        owner_data;
  logic        grant_if, grant_d;
  logic        capture;

  logic [29:0] addr_q;
  logic        wen_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  lo_q;
  logic [31:0] rdata_q;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lo[0];
      2'b10:   is_misaligned = |lo;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   lane_strb = 4'b0001 << lo;
      2'b01:   lane_strb = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   lane_wdata = {4{wdata[7:0]}};
      2'b01:   lane_wdata = {2{wdata[15:0]}};
      default: lane_wdata = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   ext = uns ? {24'd0, b} : 32'(b);
      2'b01:   ext = uns ? {16'd0, h} : 32'(h);
      default: ext = word;
    endcase
    load_extract = ext;
  endfunction

  // Grant only in IDLE; a tie goes to whichever side prio_data points at.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state == IDLE && i_rst_n) begin
      if (i_d_req && (!i_if_req || prio_data)) grant_d  = 1'b1;
      else if (i_if_req)                       grant_if = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d)       state_next = is_misaligned(i_d_size, i_d_addr[1:0]) ? FAULT : ISSUE;
        else if (grant_if) state_next = ISSUE;
      end
      ISSUE:   if (i_mem_ready) state_next = i_mem_rvalid ? RESP : WAIT;
      WAIT:    if (i_mem_rvalid) state_next = RESP;
      RESP:    state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data is taken either from the combined ready+rvalid ISSUE cycle or in WAIT.
  assign capture = i_mem_rvalid && ((state == ISSUE && i_mem_ready) || state == WAIT);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      prio_data  <= 1'b1;
      owner_data <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_d) begin
        owner_data <= 1'b1;
        prio_data  <= 1'b0;
      end else if (grant_if) begin
        owner_data <= 1'b0;
        prio_data  <= 1'b1;
      end
    end
  end

  // Accept stage: transaction fields latched at grant, held stable through ISSUE.
  always_ff @(posedge i_clk) begin
    if (grant_d) begin
      addr_q     <= i_d_addr[31:2];
      wen_q      <= i_d_wen;
      wstrb_q    <= i_d_wen ? lane_strb(i_d_size, i_d_addr[1:0]) : 4'b1111;
      wdata_q    <= lane_wdata(i_d_size, i_d_wdata);
      size_q     <= i_d_size;
      unsigned_q <= i_d_unsigned;
      lo_q       <= i_d_addr[1:0];
    end else if (grant_if) begin
      addr_q     <= i_if_addr;
      wen_q      <= 1'b0;
      wstrb_q    <= 4'b1111;
      wdata_q    <= '0;
      size_q     <= 2'b10;
      unsigned_q <= 1'b0;
      lo_q       <= 2'b00;
    end
    if (capture) rdata_q <= i_mem_rdata;
  end

  // Response stage: all outputs derive from state so they read zero outside their window.
  always_comb begin
    o_if_ready  = grant_if;
    o_d_ready   = grant_d;
    o_mem_valid = (state == ISSUE);
    o_mem_addr  = (state == ISSUE) ? addr_q  : '0;
    o_mem_wen   = (state == ISSUE) ? wen_q   : 1'b0;
    o_mem_wstrb = (state == ISSUE) ? wstrb_q : '0;
    o_mem_wdata = (state == ISSUE) ? wdata_q : '0;
    o_if_rvalid = (state == RESP) && !owner_data;
    o_if_rdata  = o_if_rvalid ? rdata_q : '0;
    o_d_rvalid  = ((state == RESP) && owner_data) || (state == FAULT);
    o_d_fault   = (state == FAULT);
    o_d_rdata   = ((state == RESP) && owner_data && !wen_q)
                  ? load_extract(rdata_q, size_q, lo_q, unsigned_q) : '0;
  end

endmodule

// File: tb/tb_letc_core_mem_arbiter.sv
module tb_letc_core_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_if_req;
  logic [29:0] i_if_addr;
  logic        o_if_ready, o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_d_req;
  logic [31:0] i_d_addr;
  logic        i_d_wen;
  logic [1:0]  i_d_size;
  logic        i_d_unsigned;
  logic [31:0] i_d_wdata;
  logic        o_d_ready, o_d_rvalid, o_d_fault;
  logic [31:0] o_d_rdata;
  logic        o_mem_valid, i_mem_ready, o_mem_wen;
  logic [29:0] o_mem_addr;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] o_mem_wdata;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          fault;
  } exp_t;
  exp_t sb[$];

  letc_core_mem_arbiter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_ready(o_if_ready),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_addr(i_d_addr), .i_d_wen(i_d_wen), .i_d_size(i_d_size),
    .i_d_unsigned(i_d_unsigned), .i_d_wdata(i_d_wdata), .o_d_ready(o_d_ready),
    .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata), .o_d_fault(o_d_fault),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
    .o_mem_wen(o_mem_wen), .o_mem_wstrb(o_mem_wstrb), .o_mem_wdata(o_mem_wdata),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Response monitor: every rvalid pulse must match the oldest expected entry.
  always @(negedge i_clk) begin
    #2;
    if (o_if_rvalid || o_d_rvalid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 32'(o_if_rvalid | o_d_rvalid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_owner_d", 32'(o_d_rvalid), 32'(e.is_d));
        chk("resp_owner_if", 32'(o_if_rvalid), 32'(!e.is_d));
        chk("resp_rdata", e.is_d ? o_d_rdata : o_if_rdata, e.rdata);
        chk("resp_fault", 32'(o_d_fault), 32'(e.fault));
      end
    end
  end

  task automatic set_d(input logic [31:0] addr, input logic wen, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    i_d_req = 1'b1; i_d_addr = addr; i_d_wen = wen; i_d_size = size;
    i_d_unsigned = uns; i_d_wdata = wdata;
  endtask

  // Called right after a negedge with the request(s) already driven.
  task automatic run(input bit exp_d, input bit fault, input logic [29:0] eaddr,
                     input logic [3:0] estrb, input logic [31:0] ewdata,
                     input logic [31:0] mrdata, input logic [31:0] erdata, input bit fast);
    int n;
    n = 0;
    #1;
    while (!(o_if_ready || o_d_ready) && n < 20) begin
      @(negedge i_clk); #1; n++;
    end
    if (n >= 20) begin
      chk("grant_timeout", 32'd0, 32'd1);
      return;
    end
    chk("grant_d", 32'(o_d_ready), 32'(exp_d));
    chk("grant_if", 32'(o_if_ready), 32'(!exp_d));
    sb.push_back('{exp_d, erdata, fault});
    @(negedge i_clk);
    if (exp_d) i_d_req = 1'b0; else i_if_req = 1'b0;
    #1;
    if (fault) begin
      chk("fault_no_mem", 32'(o_mem_valid), 32'd0);
      chk("fault_lat", 32'(o_d_fault), 32'd1);
      @(negedge i_clk);
      return;
    end
    chk("mem_valid", 32'(o_mem_valid), 32'd1);
    chk("mem_addr", 32'(o_mem_addr), 32'(eaddr));
    chk("mem_wstrb", 32'(o_mem_wstrb), 32'(estrb));
    if (estrb != 4'b1111 || ewdata != 32'd0) chk("mem_wdata", o_mem_wdata, ewdata);
    i_mem_ready = 1'b1;
    if (fast) begin
      i_mem_rvalid = 1'b1; i_mem_rdata = mrdata;
    end
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    if (!fast) begin
      i_mem_rvalid = 1'b1; i_mem_rdata = mrdata;
      #1;
      chk("wait_no_early_resp", 32'(o_if_rvalid | o_d_rvalid), 32'd0);
      @(negedge i_clk);
    end
    i_mem_rvalid = 1'b0;
    i_mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("resp_lat", 32'(o_if_rvalid | o_d_rvalid), 32'd1);
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_if_req = 1'b0; i_if_addr = '0; i_d_req = 1'b0; i_d_addr = '0;
    i_d_wen = 1'b0; i_d_size = 2'b10; i_d_unsigned = 1'b0; i_d_wdata = '0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_outputs", {o_if_ready, o_if_rvalid, o_d_ready, o_d_rvalid, o_d_fault,
                        o_mem_valid, o_mem_wen, o_mem_wstrb}, 32'd0);
    chk("rst_data", o_if_rdata | o_d_rdata | o_mem_wdata | 32'(o_mem_addr), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // fetch only, slow memory
    i_if_req = 1'b1; i_if_addr = 30'(32'h40 >> 2);
    run(1'b0, 1'b0, 30'h10, 4'b1111, 32'd0, 32'h0051_3093, 32'h0051_3093, 1'b0);

    // contention: d, if, d, if
    for (int k = 0; k < 4; k++) begin
      i_if_req = 1'b1; i_if_addr = 30'h20 + 30'(k);
      set_d(32'h300, 1'b0, 2'b10, 1'b0, 32'd0);
      if (k % 2 == 0)
        run(1'b1, 1'b0, 30'hC0, 4'b1111, 32'd0, 32'h1111_0000 + 32'(k), 32'h1111_0000 + 32'(k), 1'b1);
      else
        run(1'b0, 1'b0, 30'h20 + 30'(k), 4'b1111, 32'd0, 32'h2222_0000 + 32'(k), 32'h2222_0000 + 32'(k), 1'b1);
    end
    i_if_req = 1'b0; i_d_req = 1'b0;
    @(negedge i_clk);

    // stores
    set_d(32'h103, 1'b1, 2'b00, 1'b0, 32'h0000_00AB);
    run(1'b1, 1'b0, 30'h40, 4'b1000, 32'hABAB_ABAB, 32'h5555_5555, 32'd0, 1'b0);
    set_d(32'h106, 1'b1, 2'b01, 1'b0, 32'h1234_BEEF);
    run(1'b1, 1'b0, 30'h41, 4'b1100, 32'hBEEF_BEEF, 32'h5555_5555, 32'd0, 1'b1);
    set_d(32'h108, 1'b1, 2'b10, 1'b0, 32'hCAFE_F00D);
    run(1'b1, 1'b0, 30'h42, 4'b1111, 32'hCAFE_F00D, 32'h5555_5555, 32'd0, 1'b0);

    // loads
    set_d(32'h102, 1'b0, 2'b01, 1'b0, 32'd0);
    run(1'b1, 1'b0, 30'h40, 4'b1111, 32'd0, 32'h80FF_1234, 32'hFFFF_80FF, 1'b0);
    set_d(32'h102, 1'b0, 2'b01, 1'b1, 32'd0);
    run(1'b1, 1'b0, 30'h40, 4'b1111, 32'd0, 32'h80FF_1234, 32'h0000_80FF, 1'b1);
    set_d(32'h101, 1'b0, 2'b00, 1'b0, 32'd0);
    run(1'b1, 1'b0, 30'h40, 4'b1111, 32'd0, 32'h80FF_1234, 32'h0000_0012, 1'b0);
    set_d(32'h103, 1'b0, 2'b00, 1'b0, 32'd0);
    run(1'b1, 1'b0, 30'h40, 4'b1111, 32'd0, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0);
    set_d(32'h103, 1'b0, 2'b00, 1'b1, 32'd0);
    run(1'b1, 1'b0, 30'h40, 4'b1111, 32'd0, 32'h80FF_1234, 32'h0000_0080, 1'b1);

    // faults
    set_d(32'h202, 1'b0, 2'b10, 1'b0, 32'd0);
    run(1'b1, 1'b1, 30'h0, 4'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    set_d(32'h200, 1'b0, 2'b11, 1'b0, 32'd0);
    run(1'b1, 1'b1, 30'h0, 4'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    set_d(32'h201, 1'b1, 2'b01, 1'b0, 32'd0);
    run(1'b1, 1'b1, 30'h0, 4'b0, 32'd0, 32'd0, 32'd0, 1'b0);

    // reset during WAIT, late rvalid must be ignored
    set_d(32'h300, 1'b0, 2'b10, 1'b0, 32'd0);
    #1;
    chk("rst_test_grant", 32'(o_d_ready), 32'd1);
    @(negedge i_clk);
    i_d_req = 1'b0; i_mem_ready = 1'b1;
    @(negedge i_clk);
    i_mem_ready = 1'b0; i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("rst_mid_mem_valid", 32'(o_mem_valid), 32'd0);
    @(negedge i_clk);
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0BAD_0BAD;
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    #1;
    chk("rst_late_rvalid", 32'(o_d_rvalid | o_if_rvalid), 32'd0);
    @(negedge i_clk);
    i_if_req = 1'b1; i_if_addr = 30'h55;
    #1;
    chk("post_rst_ready", 32'(o_if_ready), 32'd1);
    run(1'b0, 1'b0, 30'h55, 4'b1111, 32'd0, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0);

    repeat (3) @(negedge i_clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
